pad_pwr_seq: RTL and testbench

//  Core-side power-up/power-down sequencer for the ASIC pad ring.

---
 rtl/pad_pwr_seq_pkg.sv | 69 ++++++
 rtl/pad_pwr_seq_bit_sync.sv | 26 ++
 rtl/pad_pwr_seq.sv | 120 ++++++++++++
 tb/tb_pad_pwr_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_pwr_seq_pkg.sv
// Shared types, state encodings and default timing for the pad power sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pad_pwr_seq_pkg;

   // Sequencer states; encodings are visible on state_o for debug.
   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_STABLE  = 3'd1,
      S_IE_ON   = 3'd2,
      S_RST_REL = 3'd3,
      S_RUN     = 3'd4,
      S_PD_OE   = 3'd5,
      S_PD_RST  = 3'd6,
      S_HALT    = 3'd7
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_STABLE_CYC  = 16;
   localparam int DEF_IE_CYC      = 8;
   localparam int DEF_OE_CYC      = 8;
   localparam int DEF_CNT_W       = 5;

   // Pad/core control bundle driven from the state register.
   typedef struct packed {
      logic ie;
      logic oe;
      logic rst;
      logic ready;
   } pad_ctl_t;

   // Safe pad state: pads isolated, core held in reset.
   localparam pad_ctl_t CTL_SAFE = '{ie: 1'b0, oe: 1'b0, rst: 1'b1, ready: 1'b0};

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // True when a counter of width w can hold every phase length.
   function automatic bit cnt_w_fits(input int w, input int a, input int b, input int c);
      return max3(a, b, c) <= ((1 << w) - 1);
   endfunction

   // Output decode per state; anything not listed keeps the pads safe.
   function automatic pad_ctl_t decode(input state_t s);
      pad_ctl_t c;
      c = CTL_SAFE;
      case (s)
         S_IE_ON:   c.ie = 1'b1;
         S_RST_REL,
         S_PD_OE: begin
            c.ie  = 1'b1;
            c.rst = 1'b0;
         end
         S_RUN: begin
            c.ie    = 1'b1;
            c.oe    = 1'b1;
            c.rst   = 1'b0;
            c.ready = 1'b1;
         end
         S_PD_RST:  c.ie = 1'b1;
         default:   c = CTL_SAFE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pad_pwr_seq_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level input.
// Latency: STAGES clk cycles from input change to output change.
// Backpressure: none; free-running level path.
module pad_pwr_seq_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   (* dont_touch = "true" *) logic [STAGES-1:0] chain;

   // Shift the async level through the chain; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   assign dout = chain[STAGES-1];

endmodule

// File: rtl/pad_pwr_seq.sv
// Pad-ring power sequencer: holds pads safe until IO supply is stable, then releases IE, core reset, OE in order.
// Latency: poc_ok_i rise to ready_o rise = SYNC_STAGES+1+STABLE_CYC+IE_CYC+OE_CYC+1 cycles; outputs lag state by 1.
// Backpressure: none; supply loss forces OFF immediately, shutdown is a level request honoured only in RUN.
module pad_pwr_seq
   import pad_pwr_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int STABLE_CYC  = DEF_STABLE_CYC,
   parameter int IE_CYC      = DEF_IE_CYC,
   parameter int OE_CYC      = DEF_OE_CYC,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       poc_ok_i,
   input  logic       pdown_req_i,
   output logic       pad_ie_o,
   output logic       pad_oe_o,
   output logic       core_rst_o,
   output logic       ready_o,
   output logic [2:0] state_o
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("pad_pwr_seq: SYNC_STAGES must be at least 2");
   end
   if (!cnt_w_fits(CNT_W, STABLE_CYC, IE_CYC, OE_CYC)) begin : g_bad_cnt_w
      $error("pad_pwr_seq: CNT_W too narrow for the phase lengths");
   end

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] IE_LAST     = CNT_W'(IE_CYC - 1);
   localparam logic [CNT_W-1:0] OE_LAST     = CNT_W'(OE_CYC - 1);

   logic             poc_s;
   state_t           state;
   state_t           state_q;
   logic [CNT_W-1:0] cnt;
   pad_ctl_t         ctl;

   pad_pwr_seq_bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_poc_sync (
      .clk  (clk_i),
      .rst  (rst_i),
      .din  (poc_ok_i),
      .dout (poc_s)
   );

   // Sequencer FSM with one shared phase counter; outputs and the debug state are
   // registered copies of the current state so they stay mutually consistent.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_OFF;
         state_q <= S_OFF;
         cnt     <= '0;
         ctl     <= CTL_SAFE;
      end else begin
         ctl     <= decode(state);
         state_q <= state;
         case (state)
            S_OFF: begin
               cnt <= '0;
               if (poc_s) state <= S_STABLE;
            end
            S_STABLE: begin
               if (!poc_s) begin
                  state <= S_OFF;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state <= S_IE_ON;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_IE_ON: begin
               if (!poc_s) begin
                  state <= S_OFF;
                  cnt   <= '0;
               end else if (cnt == IE_LAST) begin
                  state <= S_RST_REL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RST_REL: begin
               if (!poc_s) begin
                  state <= S_OFF;
                  cnt   <= '0;
               end else if (cnt == OE_LAST) begin
                  state <= S_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!poc_s)           state <= S_OFF;
               else if (pdown_req_i) state <= S_PD_OE;
            end
            S_PD_OE: state <= poc_s ? S_PD_RST : S_OFF;
            S_PD_RST: state <= poc_s ? S_HALT : S_OFF;
            // Only a full power cycle with the request withdrawn re-arms the sequence.
            S_HALT: begin
               if (!pdown_req_i && !poc_s) state <= S_OFF;
            end
            default: state <= S_OFF;
         endcase
      end
   end

   assign pad_ie_o   = ctl.ie;
   assign pad_oe_o   = ctl.oe;
   assign core_rst_o = ctl.rst;
   assign ready_o    = ctl.ready;
   assign state_o    = state_q;

endmodule

// File: tb/tb_pad_pwr_seq.sv
// Bench for pad_pwr_seq: table of timed input steps with expected outputs, scoreboarded per cycle,
// followed by random supply/shutdown stimulus with per-cycle output invariant checks.
module tb_pad_pwr_seq;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       poc_ok_i;
   logic       pdown_req_i;
   logic       pad_ie_o;
   logic       pad_oe_o;
   logic       core_rst_o;
   logic       ready_o;
   logic [2:0] state_o;

   always #5 clk = ~clk;

   pad_pwr_seq dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .poc_ok_i    (poc_ok_i),
      .pdown_req_i (pdown_req_i),
      .pad_ie_o    (pad_ie_o),
      .pad_oe_o    (pad_oe_o),
      .core_rst_o  (core_rst_o),
      .ready_o     (ready_o),
      .state_o     (state_o)
   );

   // Expected output vectors {ie, oe, core_rst, ready, state}.
   localparam logic [6:0] V_OFF    = 7'b0010_000;
   localparam logic [6:0] V_STABLE = 7'b0010_001;
   localparam logic [6:0] V_IE     = 7'b1010_010;
   localparam logic [6:0] V_REL    = 7'b1000_011;
   localparam logic [6:0] V_RUN    = 7'b1101_100;
   localparam logic [6:0] V_PDOE   = 7'b1000_101;
   localparam logic [6:0] V_PDRST  = 7'b1010_110;
   localparam logic [6:0] V_HALT   = 7'b0010_111;

   typedef struct {
      int         at;
      logic       rst;
      logic       poc;
      logic       pdown;
      int         chk;
      logic [6:0] exp;
      string      nm;
   } vec_t;

   typedef struct {
      int         at;
      logic [6:0] exp;
      string      nm;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   drain_req = 1'b0;
   bit   drain_done = 1'b0;

   logic [6:0] got;
   assign got = {pad_ie_o, pad_oe_o, core_rst_o, ready_o, state_o};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void row(input int at, input logic r, input logic p, input logic d,
                               input int chk, input logic [6:0] e, input string nm);
      vec_t v;
      v.at = at; v.rst = r; v.poc = p; v.pdown = d; v.chk = chk; v.exp = e; v.nm = nm;
      tbl.push_back(v);
   endfunction

   function automatic void sb_push(input int at, input logic [6:0] e, input string nm);
      sb_t s;
      int  idx;
      s.at = at; s.exp = e; s.nm = nm;
      idx = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].at > at) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sample on the falling edge: invariants every cycle, then due scoreboard entries.
   always @(negedge clk) begin
      sb_t e;
      if (cyc >= 1) begin
         n_cmp++;
         if (pad_oe_o !== 1'b0 && (pad_ie_o !== 1'b1 || core_rst_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL inv_oe cyc=%0d oe=%b ie=%b core_rst=%b required ie=1 core_rst=0",
                     cyc, pad_oe_o, pad_ie_o, core_rst_o);
         end
         n_cmp++;
         if (ready_o !== ((state_o == 3'd4) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL inv_ready cyc=%0d ready=%b state=%0d required ready==(state==RUN)",
                     cyc, ready_o, state_o);
         end
      end
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         n_cmp++;
         if (e.at != cyc || got !== e.exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d due=%0d got=%b required=%b (ie,oe,rst,rdy,state)",
                     e.nm, cyc, e.at, got, e.exp);
         end
      end
      if (drain_req && !drain_done) begin
         drain_done = 1'b1;
         n_cmp++;
         if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain pending=%0d required=0", sb.size());
         end
      end
   end

   initial begin
      rst_i       = 1'b1;
      poc_ok_i    = 1'b0;
      pdown_req_i = 1'b0;

      // at, rst, poc, pdown, check offset, expected, name
      row(0,   1, 1, 1,  1, V_OFF,    "reset_c1");
      row(1,   1, 1, 1,  1, V_OFF,    "reset_c2");
      row(2,   1, 0, 0,  1, V_OFF,    "reset_c3");
      row(3,   0, 0, 0,  5, V_OFF,    "off_idle");
      row(10,  0, 1, 0, 19, V_STABLE, "stable_hold");
      row(10,  0, 1, 0, 20, V_IE,     "ie_rise");
      row(10,  0, 1, 0, 27, V_IE,     "rst_held");
      row(10,  0, 1, 0, 28, V_REL,    "rst_release");
      row(10,  0, 1, 0, 35, V_REL,    "pre_run");
      row(10,  0, 1, 0, 36, V_RUN,    "ready_rise");
      row(50,  0, 1, 1,  1, V_RUN,    "pd_req_lag");
      row(50,  0, 1, 1,  2, V_PDOE,   "pd_oe_drop");
      row(50,  0, 1, 1,  3, V_PDRST,  "pd_core_rst");
      row(50,  0, 1, 1,  4, V_HALT,   "pd_ie_drop");
      row(60,  0, 1, 0,  5, V_HALT,   "halt_poc_high");
      row(70,  0, 0, 1,  6, V_HALT,   "halt_pdown_high");
      row(80,  0, 0, 0,  1, V_HALT,   "halt_exit_lag");
      row(80,  0, 0, 0,  2, V_OFF,    "halt_exit");
      row(90,  0, 1, 0, 35, V_REL,    "run2_pre");
      row(90,  0, 1, 0, 36, V_RUN,    "run2");
      row(130, 0, 0, 0,  3, V_RUN,    "brown_lag");
      row(130, 0, 0, 0,  4, V_OFF,    "brownout");
      row(140, 0, 1, 0,  5, V_STABLE, "glitch_stable");
      row(150, 0, 0, 0,  4, V_OFF,    "glitch_off");
      row(152, 0, 1, 0,  3, V_OFF,    "glitch_still_off");
      row(152, 0, 1, 0, 35, V_REL,    "glitch_pre_run");
      row(152, 0, 1, 0, 36, V_RUN,    "glitch_run");
      row(200, 1, 0, 0,  1, V_OFF,    "rst_in_run");
      row(201, 0, 1, 0, 29, V_REL,    "rst_rel2");
      row(231, 1, 1, 0,  1, V_OFF,    "rst_pulse");
      row(232, 0, 1, 0, 19, V_STABLE, "restart_stable");
      row(232, 0, 1, 0, 20, V_IE,     "restart_ie");
      row(232, 0, 1, 0, 36, V_RUN,    "restart_run");
      row(300, 1, 1, 1,  1, V_OFF,    "rst_again");
      row(301, 0, 1, 1, 35, V_REL,    "pd_early_pre");
      row(301, 0, 1, 1, 36, V_RUN,    "pd_early_run");
      row(301, 0, 1, 1, 37, V_PDOE,   "pd_early_oe");
      row(345, 0, 0, 0,  8, V_OFF,    "cleanup_off");

      for (int k = 0; k < tbl.size(); k++) begin
         while (cyc < tbl[k].at) tick();
         rst_i       = tbl[k].rst;
         poc_ok_i    = tbl[k].poc;
         pdown_req_i = tbl[k].pdown;
         sb_push(cyc + tbl[k].chk, tbl[k].exp, tbl[k].nm);
      end

      // Random supply and shutdown activity; invariants are checked every cycle.
      for (int i = 0; i < 10000; i++) begin
         tick();
         if ($urandom_range(99) == 0) poc_ok_i = ~poc_ok_i;
         if ($urandom_range(49) == 0) pdown_req_i = ~pdown_req_i;
         rst_i = ($urandom_range(999) == 0);
      end

      tick();
      drain_req = 1'b1;
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
